// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared widths, types and saturating add for the BNN output stage
package bnn_pkg;

  localparam int NUM_CH     = 8;
  localparam int IN_W       = 7;
  localparam int ACC_W      = 12;
  localparam int FIFO_DEPTH = 2;

  typedef logic signed [IN_W-1:0]  popcnt_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic [NUM_CH-1:0]       ch_bits_t;

  typedef struct packed {
    logic sat;
    acc_t val;
  } sat_res_t;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  function automatic acc_t sext_pop(input popcnt_t p);
    return {{(ACC_W-IN_W){p[IN_W-1]}}, p};
  endfunction

  // One guard bit is enough: |popcnt| is far smaller than the accumulator range.
  function automatic sat_res_t sat_add(input acc_t a, input popcnt_t b);
    logic [ACC_W:0] s;
    sat_res_t       r;
    s = {a[ACC_W-1], a} + {{(ACC_W+1-IN_W){b[IN_W-1]}}, b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      r.sat = 1'b1;
      r.val = s[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      r.sat = 1'b0;
      r.val = s[ACC_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/bnn_act_pool_if.sv
// rtl/bnn_act_pool_if.sv - BPU result input stream and packed-byte output stream
interface bnn_act_pool_if
  import bnn_pkg::*;
();

  logic                   in_valid;
  logic                   in_ready;
  logic                   in_first;
  logic                   in_last;
  logic [NUM_CH*IN_W-1:0] bpu_in;
  logic                   out_valid;
  logic                   out_ready;
  ch_bits_t               out_data;

  modport master (
    output in_valid, in_first, in_last, bpu_in, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_first, in_last, bpu_in, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/bnn_out_fifo.sv
// rtl/bnn_out_fifo.sv - generic synchronous FIFO with registered storage
module bnn_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/bnn_act_pool.sv
// rtl/bnn_act_pool.sv - accumulate BPU popcounts, threshold to bits, optional 2x2 OR-pool, byte FIFO
module bnn_act_pool
  import bnn_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      thr_we,
  input  logic [$clog2(NUM_CH)-1:0] thr_addr,
  input  acc_t                      thr_data,
  input  logic                      pool_en,
  output logic                      sat_err,
  bnn_act_pool_if.slave             s
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  acc_t              acc_q [NUM_CH];
  acc_t              acc_d [NUM_CH];
  acc_t              thr_q [NUM_CH];
  sat_res_t          sum   [NUM_CH];
  logic [NUM_CH-1:0] lane_sat;
  ch_bits_t          bin_bits;
  logic [1:0]        pool_cnt_q;
  ch_bits_t          pool_or_q;
  logic              pool_mode_q;
  logic              sat_err_q;
  logic              accept;
  logic              binarize;
  logic              eff_mode;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  ch_bits_t          push_data;

  // in_ready looks only at the FIFO occupancy, never at out_ready.
  assign s.in_ready = (fifo_count < CNT_W'(FIFO_DEPTH)) & ~rst;
  assign accept     = s.in_valid & s.in_ready;
  assign binarize   = accept & s.in_last;
  // A window opening this cycle already follows the live pool_en.
  assign eff_mode   = (pool_cnt_q == 2'd0) ? pool_en : pool_mode_q;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sum[c]      = sat_add(acc_q[c], popcnt_t'(s.bpu_in[c*IN_W +: IN_W]));
      acc_d[c]    = s.in_first ? sext_pop(popcnt_t'(s.bpu_in[c*IN_W +: IN_W])) : sum[c].val;
      lane_sat[c] = ~s.in_first & sum[c].sat;
      bin_bits[c] = (acc_d[c] >= thr_q[c]);
    end
  end

  assign fifo_push = binarize & (~eff_mode | (pool_cnt_q == 2'd3));
  assign push_data = eff_mode ? (pool_or_q | bin_bits) : bin_bits;
  assign fifo_pop  = ~fifo_empty & s.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        thr_q[c] <= '0;
      end
      pool_cnt_q  <= '0;
      pool_or_q   <= '0;
      pool_mode_q <= 1'b0;
      sat_err_q   <= 1'b0;
    end else begin
      if (thr_we) thr_q[thr_addr] <= thr_data;
      if (pool_cnt_q == 2'd0) pool_mode_q <= pool_en;
      if (accept) begin
        for (int c = 0; c < NUM_CH; c++) acc_q[c] <= acc_d[c];
        if (|lane_sat) sat_err_q <= 1'b1;
      end
      if (binarize && eff_mode) begin
        if (pool_cnt_q == 2'd3) begin
          pool_cnt_q <= '0;
          pool_or_q  <= '0;
        end else begin
          pool_cnt_q <= pool_cnt_q + 2'd1;
          pool_or_q  <= pool_or_q | bin_bits;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(fifo_push && fifo_full));
  end

  assign sat_err     = sat_err_q;
  assign s.out_valid = ~fifo_empty;

  bnn_out_fifo #(
    .WIDTH (NUM_CH),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (push_data),
    .pop_i       (fifo_pop),
    .pop_data_o  (s.out_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_bnn_act_pool.sv
// tb/tb_bnn_act_pool.sv - self-checking bench for bnn_act_pool
module tb_bnn_act_pool;
  import bnn_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       thr_we;
  logic [2:0] thr_addr;
  acc_t       thr_data;
  logic       pool_en;
  logic       sat_err;

  always #5 clk = ~clk;

  bnn_act_pool_if bif();

  bnn_act_pool dut (
    .clk      (clk),
    .rst      (rst),
    .thr_we   (thr_we),
    .thr_addr (thr_addr),
    .thr_data (thr_data),
    .pool_en  (pool_en),
    .sat_err  (sat_err),
    .s        (bif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: integer accumulators, a list of pending bytes.
  int         macc [8];
  int         mthr [8];
  bit         msat;
  int         mpn;
  logic [7:0] mpor;
  bit         mmode;
  logic [7:0] mq [$];

  typedef struct {
    int          thr2;
    logic        first;
    logic        last;
    logic [55:0] bpu;
    logic        has_exp;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [55:0] lane_set(input logic [55:0] base, input int c, input int v);
    logic [6:0]  x;
    logic [55:0] r;
    x = v[6:0];
    r = base;
    r[c*7 +: 7] = x;
    return r;
  endfunction

  // Lanes of 0 binarize to 1 and lanes of -1 to 0 when thresholds are 0.
  function automatic logic [55:0] byte_bpu(input logic [7:0] b);
    logic [55:0] r;
    for (int c = 0; c < 8; c++) r[c*7 +: 7] = b[c] ? 7'd0 : 7'h7F;
    return r;
  endfunction

  function automatic int lane(input logic [55:0] d, input int c);
    logic [6:0] x;
    x = d[c*7 +: 7];
    return int'($signed(x));
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 8; c++) begin
      macc[c] = 0;
      mthr[c] = 0;
    end
    msat = 0; mpn = 0; mpor = 0; mmode = 0;
    mq.delete();
  endtask

  task automatic cycle();
    bit         exp_rdy, acc, pop, mode;
    int         v;
    logic [7:0] b;
    #1;
    exp_rdy = !rst && (mq.size() < 2);
    check("in_ready", bif.in_ready, exp_rdy);
    acc = bif.in_valid && exp_rdy;
    pop = (mq.size() > 0) && bif.out_ready;
    if (rst) begin
      model_reset();
    end else begin
      if (pop) void'(mq.pop_front());
      mode = (mpn == 0) ? pool_en : mmode;
      if (mpn == 0) mmode = pool_en;
      if (acc) begin
        for (int c = 0; c < 8; c++) begin
          v = bif.in_first ? lane(bif.bpu_in, c) : macc[c] + lane(bif.bpu_in, c);
          if (v > 2047) begin v = 2047; msat = 1; end
          if (v < -2048) begin v = -2048; msat = 1; end
          macc[c] = v;
        end
        if (bif.in_last) begin
          for (int c = 0; c < 8; c++) b[c] = (macc[c] >= mthr[c]);
          if (mode) begin
            mpor = mpor | b;
            mpn++;
            if (mpn == 4) begin
              mq.push_back(mpor);
              mpor = 0;
              mpn = 0;
            end
          end else begin
            mq.push_back(b);
          end
        end
      end
      if (thr_we) mthr[thr_addr] = int'(thr_data);
    end
    @(posedge clk);
    @(negedge clk);
    check("out_valid", bif.out_valid, mq.size() > 0);
    if (mq.size() > 0) check("out_data", bif.out_data, mq[0]);
    check("sat_err", sat_err, msat);
  endtask

  task automatic drive(input logic v, input logic f, input logic l, input logic [55:0] d);
    bif.in_valid = v;
    bif.in_first = f;
    bif.in_last  = l;
    bif.bpu_in   = d;
  endtask

  task automatic wr_thr(input int a, input int v);
    drive(0, 0, 0, '0);
    thr_we   = 1;
    thr_addr = a[2:0];
    thr_data = acc_t'(v);
    cycle();
    thr_we = 0;
  endtask

  initial begin
    logic [63:0] rnd;
    model_reset();
    rst = 1; thr_we = 0; thr_addr = 0; thr_data = 0; pool_en = 0;
    bif.out_ready = 1;
    drive(0, 0, 0, '0);
    @(negedge clk);

    tbl[0] = '{0, 1, 1, lane_set(lane_set(56'd0, 0, 3), 1, -1), 1, 8'hFD};
    tbl[1] = '{5, 1, 0, lane_set(56'd0, 2, 20),  0, 8'h00};
    tbl[2] = '{5, 0, 0, lane_set(56'd0, 2, -30), 0, 8'h00};
    tbl[3] = '{5, 0, 1, lane_set(56'd0, 2, 15),  1, 8'hFF};
    tbl[4] = '{6, 1, 0, lane_set(56'd0, 2, 20),  0, 8'h00};
    tbl[5] = '{6, 0, 0, lane_set(56'd0, 2, -30), 0, 8'h00};
    tbl[6] = '{6, 0, 1, lane_set(56'd0, 2, 15),  1, 8'hFB};

    // Reset held two cycles, then released.
    cycle();
    cycle();
    check("rst_out_data", bif.out_data, 8'h00);
    rst = 0;
    cycle();
    check("rst_ready", bif.in_ready, 1);

    for (int i = 0; i < 7; i++) begin
      wr_thr(2, tbl[i].thr2);
      drive(1, tbl[i].first, tbl[i].last, tbl[i].bpu);
      cycle();
      drive(0, 0, 0, '0);
      if (tbl[i].has_exp) begin
        check("tbl_valid", bif.out_valid, 1);
        check("tbl_data", bif.out_data, tbl[i].exp);
      end
    end

    // 2x2 pool with pool_en dropped mid-window.
    wr_thr(2, 0);
    pool_en = 1;
    cycle();
    drive(1, 1, 1, byte_bpu(8'h01)); cycle();
    drive(1, 1, 1, byte_bpu(8'h02)); cycle();
    pool_en = 0;
    drive(1, 1, 1, byte_bpu(8'h00)); cycle();
    check("pool_no_early", bif.out_valid, 0);
    drive(1, 1, 1, byte_bpu(8'h80)); cycle();
    check("pool_valid", bif.out_valid, 1);
    check("pool_data", bif.out_data, 8'h83);
    drive(0, 0, 0, '0); cycle();
    drive(1, 1, 1, byte_bpu(8'h0F)); cycle();
    check("pass_data", bif.out_data, 8'h0F);
    drive(0, 0, 0, '0); cycle();

    // Backpressure: FIFO fills at two entries, third beat waits.
    bif.out_ready = 0;
    drive(1, 1, 1, byte_bpu(8'h5A)); cycle();
    drive(1, 1, 1, byte_bpu(8'hA5)); cycle();
    check("bp_ready_low", bif.in_ready, 0);
    drive(1, 1, 1, byte_bpu(8'h3C)); cycle(); cycle();
    check("bp_head0", bif.out_data, 8'h5A);
    bif.out_ready = 1;
    cycle();
    check("bp_head1", bif.out_data, 8'hA5);
    cycle();
    check("bp_head2", bif.out_data, 8'h3C);
    check("bp_ready_high", bif.in_ready, 1);
    drive(0, 0, 0, '0); cycle();

    // Saturation on ch0 with thr[0] at the positive limit.
    wr_thr(0, 2047);
    for (int k = 0; k < 40; k++) begin
      drive(1, k == 0, k == 39, lane_set(56'd0, 0, 63));
      cycle();
    end
    drive(0, 0, 0, '0);
    check("sat_set", sat_err, 1);
    check("sat_clamp_data", bif.out_data, 8'hFF);
    cycle();
    drive(1, 1, 1, lane_set(56'd0, 0, -1)); cycle();
    check("sat_neg_data", bif.out_data, 8'hFE);
    check("sat_sticky", sat_err, 1);
    drive(0, 0, 0, '0); cycle();

    // Reset in the middle of a pool window.
    pool_en = 1;
    cycle();
    drive(1, 1, 1, byte_bpu(8'h11)); cycle();
    drive(1, 1, 1, byte_bpu(8'h22)); cycle();
    rst = 1;
    drive(0, 0, 0, '0); cycle();
    rst = 0;
    pool_en = 0;
    check("midrst_sat", sat_err, 0);
    drive(1, 1, 1, byte_bpu(8'h42)); cycle();
    check("midrst_data", bif.out_data, 8'h42);
    drive(0, 0, 0, '0); cycle();

    // Randomized traffic against the model.
    for (int k = 0; k < 500; k++) begin
      rst      = ($urandom_range(0, 99) == 0);
      thr_we   = ($urandom_range(0, 7) == 0);
      thr_addr = 3'($urandom_range(0, 7));
      thr_data = acc_t'(int'($urandom_range(0, 400)) - 200);
      pool_en  = 1'($urandom_range(0, 1));
      bif.out_ready = ($urandom_range(0, 3) != 0);
      rnd = {$urandom, $urandom};
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, rnd[55:0]);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
